vending_core_n: RTL and testbench
=================================

# vending_core_n

Parametrised transaction core for the vending machine. It keeps per-channel stock and per-channel prices, runs the select → pay → vend/refund sequence, and handles admin replenish and clear. It also accumulates turnover and units sold. It sits between the keypad decoder and the 7-segment display driver, and generalises the fixed 7-channel, 3-bit processor to N channels with configurable stock and money widths, payment timeout and refund.

## Interface
Parameters:
- NCH, 7: number of channels (2..16); channel index width CHW = $clog2(NCH).
- CW, 3: stock counter width; max stock SMAX = 2^CW-1.
- MW, 8: money width for cost, paid, change and turnover; MMAX = 2^MW-1.
- PRICES, {4'd7,4'd6,4'd5,4'd4,4'd3,4'd2,4'd1}: NCH×4-bit packed unit prices; channel i uses bits [4i+3:4i]. Default is price(i) = i+1.
- INIT_STOCK, 5: stock of every channel after reset (must be ≤ SMAX).
- TIMEOUT, 1000: idle cycles allowed in PAY before auto-refund (≥ 2).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- admin_mode  in  1  1 = administrator; blocks customer selection.
- sel_valid  in  1  customer selection strobe (1 cycle).
- sel_ch  in  CHW  selected channel (shared with repl).
- sel_qty  in  CW  requested quantity (shared with repl as replenish amount).
- coin_valid  in  1  coin/payment strobe.
- coin_val  in  4  value credited by this strobe (0..15).
- cancel  in  1  customer cancel.
- repl_valid  in  1  admin replenish strobe.
- clr_stock  in  1  admin: zero all stock.
- clr_turnover  in  1  admin: zero turnover and sold_total.
- state  out  2  0 IDLE, 1 PAY, 2 VEND, 3 REFUND.
- cost  out  MW  price × qty of the current transaction.
- paid  out  MW  money credited so far.
- change  out  MW  change or refund amount of the last completed transaction.
- vend_pulse  out  1  high during VEND.
- refund_pulse  out  1  high during REFUND.
- err  out  1  1-cycle pulse on a rejected request.
- stock_flat  out  NCH×CW  channel i at bits [CW·i+CW-1:CW·i].
- turnover  out  MW  saturating sales total.
- sold_total  out  MW  saturating units sold.

## Operation
- Reset values:
  - state = IDLE.
  - cost, paid, change, turnover and sold_total = 0.
  - vend_pulse, refund_pulse and err = 0.
  - every stock = INIT_STOCK.
  - Reset asserted mid-transaction abandons it; no refund is issued.
- IDLE, customer path (admin_mode = 0), on sel_valid:
  - Reject if sel_ch ≥ NCH, sel_qty = 0, sel_qty > stock[sel_ch], or price×qty > MMAX. Rejection pulses err and stays in IDLE.
  - Otherwise latch ch and qty, set cost = price(ch)×sel_qty, clear paid and change, and go to PAY.
- IDLE, admin path (admin_mode = 1):
  - sel_valid is ignored.
  - clr_stock sets all stock to 0.
  - Otherwise, repl_valid sets stock[sel_ch] = min(stock + sel_qty, SMAX). If sel_ch ≥ NCH, pulse err and leave stock unchanged.
  - clr_turnover may coincide with either of the above and zeroes turnover and sold_total.
- Admin inputs outside IDLE are ignored.
- PAY:
  - coin_valid sets paid ← min(paid + coin_val, MMAX) and restarts the inactivity timer.
  - If the post-add paid ≥ cost, go to VEND.
  - cancel goes to REFUND. On the same cycle as coin_valid, cancel wins, and the coin is still credited before the refund.
  - If the timer reaches TIMEOUT with no coin, go to REFUND.
- VEND (1 cycle), with effects on the exit edge:
  - stock[ch] −= qty.
  - turnover ← min(turnover + cost, MMAX).
  - sold_total ← min(sold_total + qty, MMAX).
  - change ← paid − cost.
  - Go to IDLE.
- REFUND (1 cycle):
  - change ← paid on the exit edge.
  - Stock and turnover are unchanged.
  - Go to IDLE.
- cost, paid and change hold their values in IDLE until the next accepted selection, so the display can show them.
- All arithmetic is unsigned. Every sum is computed one bit wider, then saturated.

## Timing
- Selection sampled at edge k: state = PAY and cost are valid after edge k.
- Final coin sampled at edge k: paid is updated and state = VEND after edge k. vend_pulse is high for cycle k..k+1. Stock, turnover and change update at edge k+1, when state returns to IDLE.
- Timeout: the timer clears on PAY entry and on each coin. REFUND is entered on the edge on which the TIMEOUT-th consecutive coin-free PAY cycle is counted.
- err is registered: high for exactly one cycle after the offending edge.
- A new sel_valid is accepted on the first IDLE cycle after VEND or REFUND.
- Outputs are registered except vend_pulse and refund_pulse, which decode state.

## Test plan
- Reset, then select ch 2 qty 2 and pay coins 3, 4 → cost = 6, paid = 7, VEND for 1 cycle; then stock[2] = 3, change = 1, turnover = 6, sold_total = 2.
- Select ch 0 qty 6 with stock 5 → err pulses 1 cycle, state stays IDLE. Select ch 7 with NCH = 7 → err.
- Select ch 4 qty 1, pay coin 2, then cancel on the same cycle as coin 1 → REFUND, change = 3, stock[4] still 5, turnover unchanged.
- Select ch 1 qty 1, pay coin 1, then no coins (TIMEOUT = 10) → refund_pulse after 10 idle cycles, change = 1.
- Admin mode: repl ch 3 qty 7 with CW = 3 → stock[3] = 7 (saturated from 12). clr_stock → all 0. A customer select while in admin mode is ignored.
- Assert rst during PAY with paid = 4 → after the edge, state = IDLE, paid = 0, stock = INIT_STOCK, no refund_pulse.

Source files
------------

// File: rtl/vending_core_n.sv
// rtl/vending_core_n.sv - N-channel vending transaction core: stock, pricing, pay/vend/refund, turnover
module vending_core_n #(
    parameter int NCH = 7,
    parameter int CW = 3,
    parameter int MW = 8,
    parameter logic [NCH*4-1:0] PRICES = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1},
    parameter int INIT_STOCK = 5,
    parameter int TIMEOUT = 1000,
    localparam int CHW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              admin_mode,
    input  logic              sel_valid,
    input  logic [CHW-1:0]    sel_ch,
    input  logic [CW-1:0]     sel_qty,
    input  logic              coin_valid,
    input  logic [3:0]        coin_val,
    input  logic              cancel,
    input  logic              repl_valid,
    input  logic              clr_stock,
    input  logic              clr_turnover,
    output logic [1:0]        state,
    output logic [MW-1:0]     cost,
    output logic [MW-1:0]     paid,
    output logic [MW-1:0]     change,
    output logic              vend_pulse,
    output logic              refund_pulse,
    output logic              err,
    output logic [NCH*CW-1:0] stock_flat,
    output logic [MW-1:0]     turnover,
    output logic [MW-1:0]     sold_total
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = 4 + CW;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAY = 2'd1, S_VEND = 2'd2, S_REFUND = 2'd3} state_t;

    state_t          st;
    logic [CW-1:0]   stock [NCH];
    logic [CHW-1:0]  ch;
    logic [CW-1:0]   qty;
    logic [TW-1:0]   timer;

    logic            sel_in_range;
    logic [CW-1:0]   sel_stock;
    logic [3:0]      sel_price;
    logic [PW-1:0]   sel_prod;
    logic [PW+MW-1:0] prod_w;
    logic            prod_over;
    logic [MW:0]     paid_sum;
    logic [MW-1:0]   paid_next;
    logic [MW:0]     turn_sum;
    logic [MW:0]     sold_sum;
    logic [CW:0]     repl_sum;

    // Channel lookups are done by compare rather than direct indexing so that
    // out-of-range channel numbers read as zero instead of indexing past NCH.
    always_comb begin
        sel_stock = '0;
        sel_price = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_ch == CHW'(i)) begin
                sel_stock = stock[i];
                sel_price = PRICES[4*i +: 4];
            end
        end
        sel_in_range = ({1'b0, sel_ch} < (CHW+1)'(NCH));
        sel_prod     = PW'(sel_price) * PW'(sel_qty);
        prod_w       = (PW+MW)'(sel_prod);
        prod_over    = prod_w > (PW+MW)'({MW{1'b1}});
        paid_sum     = {1'b0, paid} + (MW+1)'(coin_val);
        paid_next    = paid_sum[MW] ? '1 : paid_sum[MW-1:0];
        turn_sum     = {1'b0, turnover} + {1'b0, cost};
        sold_sum     = {1'b0, sold_total} + (MW+1)'(qty);
        repl_sum     = {1'b0, sel_stock} + {1'b0, sel_qty};
    end

    always_comb begin
        stock_flat = '0;
        for (int i = 0; i < NCH; i++) begin
            stock_flat[CW*i +: CW] = stock[i];
        end
    end

    assign state        = st;
    assign vend_pulse   = (st == S_VEND);
    assign refund_pulse = (st == S_REFUND);

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            cost       <= '0;
            paid       <= '0;
            change     <= '0;
            turnover   <= '0;
            sold_total <= '0;
            err        <= 1'b0;
            timer      <= '0;
            ch         <= '0;
            qty        <= '0;
            for (int i = 0; i < NCH; i++) begin
                stock[i] <= CW'(INIT_STOCK);
            end
        end else begin
            err <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (admin_mode) begin
                        if (clr_stock) begin
                            for (int i = 0; i < NCH; i++) begin
                                stock[i] <= '0;
                            end
                        end else if (repl_valid) begin
                            if (!sel_in_range) begin
                                err <= 1'b1;
                            end else begin
                                for (int i = 0; i < NCH; i++) begin
                                    if (sel_ch == CHW'(i)) begin
                                        stock[i] <= repl_sum[CW] ? '1 : repl_sum[CW-1:0];
                                    end
                                end
                            end
                        end
                        if (clr_turnover) begin
                            turnover   <= '0;
                            sold_total <= '0;
                        end
                    end else if (sel_valid) begin
                        if (!sel_in_range || sel_qty == '0 || sel_qty > sel_stock || prod_over) begin
                            err <= 1'b1;
                        end else begin
                            ch     <= sel_ch;
                            qty    <= sel_qty;
                            cost   <= prod_w[MW-1:0];
                            paid   <= '0;
                            change <= '0;
                            timer  <= '0;
                            st     <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (coin_valid) begin
                        paid <= paid_next;
                    end
                    // Cancel takes priority, but a coin on the same cycle is still credited.
                    if (cancel) begin
                        st <= S_REFUND;
                    end else if (coin_valid) begin
                        timer <= '0;
                        if (paid_next >= cost) begin
                            st <= S_VEND;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        st <= S_REFUND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_VEND: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (ch == CHW'(i)) begin
                            stock[i] <= stock[i] - qty;
                        end
                    end
                    turnover   <= turn_sum[MW] ? '1 : turn_sum[MW-1:0];
                    sold_total <= sold_sum[MW] ? '1 : sold_sum[MW-1:0];
                    change     <= paid - cost;
                    st         <= S_IDLE;
                end
                S_REFUND: begin
                    change <= paid;
                    st     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_core_n.sv
// tb/tb_vending_core_n.sv - scoreboard bench for vending_core_n (NCH=7, CW=3, MW=8, TIMEOUT=10)
module tb_vending_core_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        admin_mode;
    logic        sel_valid;
    logic [2:0]  sel_ch;
    logic [2:0]  sel_qty;
    logic        coin_valid;
    logic [3:0]  coin_val;
    logic        cancel;
    logic        repl_valid;
    logic        clr_stock;
    logic        clr_turnover;
    logic [1:0]  state;
    logic [7:0]  cost;
    logic [7:0]  paid;
    logic [7:0]  change;
    logic        vend_pulse;
    logic        refund_pulse;
    logic        err;
    logic [20:0] stock_flat;
    logic [7:0]  turnover;
    logic [7:0]  sold_total;

    vending_core_n #(.TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .admin_mode(admin_mode),
        .sel_valid(sel_valid), .sel_ch(sel_ch), .sel_qty(sel_qty),
        .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel),
        .repl_valid(repl_valid), .clr_stock(clr_stock), .clr_turnover(clr_turnover),
        .state(state), .cost(cost), .paid(paid), .change(change),
        .vend_pulse(vend_pulse), .refund_pulse(refund_pulse), .err(err),
        .stock_flat(stock_flat), .turnover(turnover), .sold_total(sold_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;      // 0 err, 1 vend, 2 refund
        logic [7:0]  cost;
        logic [7:0]  paid;
        logic [7:0]  change;
        logic [7:0]  turnover;
        logic [7:0]  sold;
        logic [20:0] stock;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_stock [7];
    logic [7:0] exp_turn;
    logic [7:0] exp_sold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [20:0] pack_stock();
        logic [20:0] p;
        for (int i = 0; i < 7; i++) p[3*i +: 3] = exp_stock[i];
        return p;
    endfunction

    function automatic void expect_ev(input int kind, input logic [7:0] c,
                                      input logic [7:0] p, input logic [7:0] chg);
        exp_t e;
        e.kind = kind; e.cost = c; e.paid = p; e.change = chg;
        e.turnover = exp_turn; e.sold = exp_sold; e.stock = pack_stock();
        q.push_back(e);
    endfunction

    // Monitor: every err / vend / refund cycle consumes one expected record.
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            if (!rst && (err || vend_pulse || refund_pulse)) begin
                kind = err ? 0 : (vend_pulse ? 1 : 2);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", kind, e.kind);
                    if (e.kind != 0) begin
                        chk("event_cost", cost, e.cost);
                        chk("event_paid", paid, e.paid);
                        @(negedge clk);
                        chk("post_state_idle", state, 0);
                        chk("post_change", change, e.change);
                        chk("post_turnover", turnover, e.turnover);
                        chk("post_sold", sold_total, e.sold);
                        chk("post_stock", stock_flat, e.stock);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic [2:0] c, input logic [2:0] n);
        sel_valid = 1'b1; sel_ch = c; sel_qty = n;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic coin(input logic [3:0] v, input logic cx);
        coin_valid = 1'b1; coin_val = v; cancel = cx;
        tick();
        coin_valid = 1'b0; cancel = 1'b0;
    endtask

    task automatic repl(input logic [2:0] c, input logic [2:0] n);
        repl_valid = 1'b1; sel_ch = c; sel_qty = n;
        tick();
        repl_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; admin_mode = 1'b0; sel_valid = 1'b0; sel_ch = '0; sel_qty = '0;
        coin_valid = 1'b0; coin_val = '0; cancel = 1'b0; repl_valid = 1'b0;
        clr_stock = 1'b0; clr_turnover = 1'b0;
        for (int i = 0; i < 7; i++) exp_stock[i] = 3'd5;
        exp_turn = 8'd0; exp_sold = 8'd0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_state", state, 0);
        chk("reset_cost", cost, 0);
        chk("reset_paid", paid, 0);
        chk("reset_change", change, 0);
        chk("reset_turnover", turnover, 0);
        chk("reset_sold", sold_total, 0);
        chk("reset_err", err, 0);
        chk("reset_stock", stock_flat, pack_stock());

        // ch2 (price 3) x2 = 6, pay 3+4 = 7 -> change 1
        exp_stock[2] = 3'd3; exp_turn = 8'd6; exp_sold = 8'd2;
        expect_ev(1, 8'd6, 8'd7, 8'd1);
        select(3'd2, 3'd2);
        chk("sel_state_pay", state, 1);
        chk("sel_cost", cost, 6);
        coin(4'd3, 1'b0);
        chk("pay_partial", paid, 3);
        coin(4'd4, 1'b0);
        chk("vend_state", state, 2);
        repeat (3) tick();

        // rejections: qty above stock, channel out of range
        expect_ev(0, 8'd0, 8'd0, 8'd0);
        select(3'd0, 3'd6);
        chk("reject_qty_idle", state, 0);
        tick();
        expect_ev(0, 8'd0, 8'd0, 8'd0);
        select(3'd7, 3'd1);
        chk("reject_ch_idle", state, 0);
        repeat (2) tick();

        // ch4 (price 5), coin 2, then coin 1 with cancel -> refund 3
        expect_ev(2, 8'd5, 8'd3, 8'd3);
        select(3'd4, 3'd1);
        coin(4'd2, 1'b0);
        coin(4'd1, 1'b1);
        chk("cancel_state", state, 3);
        repeat (3) tick();

        // ch1 (price 2), coin 1, then timeout after 10 coin-free cycles
        expect_ev(2, 8'd2, 8'd1, 8'd1);
        select(3'd1, 3'd1);
        coin(4'd1, 1'b0);
        n = 0;
        while (state != 2'd3 && n < 30) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 10);
        repeat (3) tick();

        // admin operations
        admin_mode = 1'b1;
        clr_turnover = 1'b1;
        tick();
        clr_turnover = 1'b0;
        exp_turn = 8'd0; exp_sold = 8'd0;
        chk("clr_turnover", turnover, 0);
        chk("clr_sold", sold_total, 0);
        repl(3'd3, 3'd7);
        exp_stock[3] = 3'd7;
        chk("repl_saturate", stock_flat, pack_stock());
        select(3'd0, 3'd1);
        chk("admin_sel_ignored", state, 0);
        tick();
        expect_ev(0, 8'd0, 8'd0, 8'd0);
        repl(3'd7, 3'd1);
        tick();
        chk("repl_bad_ch_stock", stock_flat, pack_stock());
        clr_stock = 1'b1;
        tick();
        clr_stock = 1'b0;
        for (int i = 0; i < 7; i++) exp_stock[i] = 3'd0;
        chk("clr_stock", stock_flat, pack_stock());
        repl(3'd3, 3'd3);
        exp_stock[3] = 3'd3;
        chk("repl_after_clr", stock_flat, pack_stock());
        admin_mode = 1'b0;
        tick();

        // reset during PAY abandons the transaction without refund
        select(3'd3, 3'd2);
        chk("pre_rst_cost", cost, 8);
        coin(4'd4, 1'b0);
        chk("pre_rst_paid", paid, 4);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) exp_stock[i] = 3'd5;
        chk("rst_state", state, 0);
        chk("rst_paid", paid, 0);
        chk("rst_cost", cost, 0);
        chk("rst_refund_pulse", refund_pulse, 0);
        chk("rst_stock", stock_flat, pack_stock());
        rst = 1'b0;
        repeat (3) tick();

        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
